// File: rtl/stoplight_pkg.sv
// Shared phase encoding and lamp patterns for the stoplight controller and its monitor.
package stoplight_pkg;

   typedef enum logic [1:0] {
      PH_IDLE = 2'd0,
      PH_RED  = 2'd1,
      PH_GRN  = 2'd2,
      PH_YEL  = 2'd3
   } phase_e;

   // Lamp vectors are ordered {r, y, g}
   localparam logic [2:0] RGB_R = 3'b100;
   localparam logic [2:0] RGB_Y = 3'b010;
   localparam logic [2:0] RGB_G = 3'b001;

   // Anything other than exactly one lit lamp decodes to IDLE
   function automatic phase_e rgb_decode(input logic [2:0] rgb);
      case (rgb)
         RGB_R:   return PH_RED;
         RGB_G:   return PH_GRN;
         RGB_Y:   return PH_YEL;
         default: return PH_IDLE;
      endcase
   endfunction

   function automatic phase_e legal_next(input phase_e p);
      case (p)
         PH_RED:  return PH_GRN;
         PH_GRN:  return PH_YEL;
         PH_YEL:  return PH_RED;
         default: return PH_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with clear and load-to-one; clear has priority over load, load over increment.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_inc,
   input  logic         i_load1,
   input  logic         i_clr,
   output logic [W-1:0] o_q
);

   localparam logic [W-1:0] LP_MAX = '1;
   localparam logic [W-1:0] LP_ONE = {{(W-1){1'b0}}, 1'b1};

   logic [W-1:0] r_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        r_q <= '0;
      else if (i_clr)                    r_q <= '0;
      else if (i_load1)                  r_q <= LP_ONE;
      else if (i_inc && (r_q != LP_MAX)) r_q <= r_q + LP_ONE;
   end

   assign o_q = r_q;

endmodule

// File: rtl/stoplight_monitor.sv
// Passive checker for stoplight lamp outputs: phase decode, dwell timing, cycle count, sticky errors.
module stoplight_monitor
   import stoplight_pkg::*;
#(
   parameter int CNT_W = 8,
   parameter int CYC_W = 16,
   parameter int G_MIN = 3,
   parameter int Y_MIN = 2,
   parameter int Y_MAX = 4,
   parameter int R_MIN = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             r,
   input  logic             y,
   input  logic             g,
   input  logic             clr_err,
   output logic [1:0]       phase,
   output logic [CNT_W-1:0] dwell,
   output logic [CYC_W-1:0] cycles,
   output logic             cycle_done,
   output logic             err_onehot,
   output logic             err_order,
   output logic             err_dwell,
   output logic             err_any
);

   localparam logic [CNT_W-1:0] LP_GMIN = CNT_W'(G_MIN);
   localparam logic [CNT_W-1:0] LP_YMIN = CNT_W'(Y_MIN);
   localparam logic [CNT_W-1:0] LP_YMAX = CNT_W'(Y_MAX);
   localparam logic [CNT_W-1:0] LP_RMIN = CNT_W'(R_MIN);

   logic [2:0]       r_s_rgb;
   phase_e           r_phase, w_phase_nxt, w_dec;
   logic             r_armed, w_armed_nxt, r_en_q;
   logic [CYC_W-1:0] r_cycles;
   logic             r_cdone, r_e_oh, r_e_ord, r_e_dw;
   logic [CNT_W-1:0] w_dwell, w_min;
   logic             w_d_inc, w_d_load1, w_d_clr, w_cyc_inc;
   logic             w_ev_oh, w_ev_ord, w_ev_dw;

   assign w_dec = rgb_decode(r_s_rgb);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_s_rgb  <= 3'b000;
         r_phase  <= PH_IDLE;
         r_armed  <= 1'b0;
         r_en_q   <= 1'b1;
         r_cycles <= '0;
         r_cdone  <= 1'b0;
         r_e_oh   <= 1'b0;
         r_e_ord  <= 1'b0;
         r_e_dw   <= 1'b0;
      end else begin
         r_en_q  <= en;
         r_cdone <= w_cyc_inc;
         if (en) begin
            r_s_rgb <= {r, y, g};
            r_phase <= w_phase_nxt;
            r_armed <= w_armed_nxt;
         end
         if (w_cyc_inc) r_cycles <= r_cycles + CYC_W'(1);
         // A fresh event in the clearing cycle leaves the flag set
         r_e_oh  <= (r_e_oh  & ~clr_err) | w_ev_oh;
         r_e_ord <= (r_e_ord & ~clr_err) | w_ev_ord;
         r_e_dw  <= (r_e_dw  & ~clr_err) | w_ev_dw;
      end
   end

   always_comb begin
      w_phase_nxt = r_phase;
      w_armed_nxt = r_armed;
      w_d_inc     = 1'b0;
      w_d_load1   = 1'b0;
      w_d_clr     = 1'b0;
      w_cyc_inc   = 1'b0;
      w_ev_oh     = 1'b0;
      w_ev_ord    = 1'b0;
      w_ev_dw     = 1'b0;
      case (r_phase)
         PH_RED:  w_min = LP_RMIN;
         PH_GRN:  w_min = LP_GMIN;
         PH_YEL:  w_min = LP_YMIN;
         default: w_min = '0;
      endcase
      if (en) begin
         if (!r_en_q) begin
            // Re-enable: drop whatever was tracked before the freeze
            w_phase_nxt = PH_IDLE;
            w_armed_nxt = 1'b0;
            w_d_clr     = 1'b1;
         end else if (r_phase == PH_IDLE) begin
            if (w_dec != PH_IDLE) begin
               w_phase_nxt = w_dec;
               w_d_load1   = 1'b1;
            end
         end else if (w_dec == PH_IDLE) begin
            w_ev_oh     = 1'b1;
            w_phase_nxt = PH_IDLE;
            w_armed_nxt = 1'b0;
            w_d_clr     = 1'b1;
         end else if (w_dec == r_phase) begin
            w_d_inc = 1'b1;
            // Dwell climbs by one per step, so equality fires exactly once per visit
            if (r_phase == PH_YEL && w_dwell == LP_YMAX) w_ev_dw = 1'b1;
         end else if (w_dec == legal_next(r_phase)) begin
            w_ev_dw     = (w_dwell < w_min);
            w_phase_nxt = w_dec;
            w_d_load1   = 1'b1;
            if (r_phase == PH_RED) w_armed_nxt = 1'b1;
            if (r_phase == PH_YEL && r_armed) w_cyc_inc = 1'b1;
         end else begin
            w_ev_ord    = 1'b1;
            w_phase_nxt = w_dec;
            w_d_load1   = 1'b1;
            w_armed_nxt = 1'b0;
         end
      end
   end

   sat_counter #(.W(CNT_W)) u_dwell (
      .clk     (clk),
      .rst_n   (rst),
      .i_inc   (w_d_inc),
      .i_load1 (w_d_load1),
      .i_clr   (w_d_clr),
      .o_q     (w_dwell)
   );

   assign phase      = r_phase;
   assign dwell      = w_dwell;
   assign cycles     = r_cycles;
   assign cycle_done = r_cdone;
   assign err_onehot = r_e_oh;
   assign err_order  = r_e_ord;
   assign err_dwell  = r_e_dw;
   assign err_any    = r_e_oh | r_e_ord | r_e_dw;

endmodule

// File: tb/tb_stoplight_monitor.sv
// Randomized and directed bench for stoplight_monitor against a behavioural lamp-rule model.
module tb_stoplight_monitor;

   localparam int CNT_W = 8;
   localparam int CYC_W = 16;
   localparam int G_MIN = 3;
   localparam int Y_MIN = 2;
   localparam int Y_MAX = 4;
   localparam int R_MIN = 3;
   localparam int DMAX  = (1 << CNT_W) - 1;
   localparam logic [2:0] LR = 3'b100, LY = 3'b010, LG = 3'b001;

   logic clk = 1'b0, rst = 1'b0, en = 1'b0, r = 1'b0, y = 1'b0, g = 1'b0, clr_err = 1'b0;
   logic [1:0]       phase;
   logic [CNT_W-1:0] dwell;
   logic [CYC_W-1:0] cycles;
   logic cycle_done, err_onehot, err_order, err_dwell, err_any;

   stoplight_monitor #(
      .CNT_W(CNT_W), .CYC_W(CYC_W), .G_MIN(G_MIN),
      .Y_MIN(Y_MIN), .Y_MAX(Y_MAX), .R_MIN(R_MIN)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .r(r), .y(y), .g(g), .clr_err(clr_err),
      .phase(phase), .dwell(dwell), .cycles(cycles), .cycle_done(cycle_done),
      .err_onehot(err_onehot), .err_order(err_order), .err_dwell(err_dwell),
      .err_any(err_any)
   );

   always #5 clk = ~clk;

   int n_vec = 0, n_mis = 0;

   // model state: phase as 0..3 (IDLE,RED,GRN,YEL), legal successor of p is p%3+1
   int   m_ph, m_dw, m_cyc;
   bit   m_arm, m_cdone, m_enp, m_yflag;
   bit   me_oh, me_or, me_dw;
   logic [2:0] m_samp;
   int   mins [4] = '{0, R_MIN, G_MIN, Y_MIN};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s got=%0d want=%0d t=%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int lamp2ph(input logic [2:0] v);
      if (v == LR) return 1;
      if (v == LG) return 2;
      if (v == LY) return 3;
      return 0;
   endfunction

   task automatic model_reset();
      m_ph = 0; m_dw = 0; m_cyc = 0; m_arm = 0; m_cdone = 0; m_enp = 1;
      m_yflag = 0; me_oh = 0; me_or = 0; me_dw = 0; m_samp = 3'b000;
   endtask

   task automatic enter(input int p);
      m_ph = p; m_dw = (p == 0) ? 0 : 1; m_yflag = 0;
   endtask

   task automatic model_step();
      int d;
      if (clr_err) begin me_oh = 0; me_or = 0; me_dw = 0; end
      m_cdone = 0;
      if (en) begin
         d = lamp2ph(m_samp);
         if (!m_enp) begin
            enter(0); m_arm = 0;
         end else if (m_ph == 0) begin
            if (d != 0) enter(d);
         end else if (d == 0) begin
            me_oh = 1; enter(0); m_arm = 0;
         end else if (d == m_ph) begin
            if (m_ph == 3 && m_dw + 1 > Y_MAX && !m_yflag) begin me_dw = 1; m_yflag = 1; end
            if (m_dw < DMAX) m_dw++;
         end else if (d == m_ph % 3 + 1) begin
            if (m_dw < mins[m_ph]) me_dw = 1;
            if (m_ph == 1) m_arm = 1;
            if (m_ph == 3 && m_arm) begin m_cyc = (m_cyc + 1) % (1 << CYC_W); m_cdone = 1; end
            enter(d);
         end else begin
            me_or = 1; enter(d); m_arm = 0;
         end
         m_samp = {r, y, g};
      end
      m_enp = en;
   endtask

   task automatic check_all();
      chk("phase", 32'(phase), 32'(m_ph));
      chk("dwell", 32'(dwell), 32'(m_dw));
      chk("cycles", 32'(cycles), 32'(m_cyc));
      chk("cycle_done", 32'(cycle_done), 32'(m_cdone));
      chk("err_onehot", 32'(err_onehot), 32'(me_oh));
      chk("err_order", 32'(err_order), 32'(me_or));
      chk("err_dwell", 32'(err_dwell), 32'(me_dw));
      chk("err_any", 32'(err_any), 32'(me_oh | me_or | me_dw));
   endtask

   // one clock: drive at negedge, model at posedge, compare at next negedge
   task automatic tick(input logic [2:0] rgb, input logic e, input logic c);
      {r, y, g} = rgb; en = e; clr_err = c;
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic hold(input logic [2:0] rgb, input int n);
      for (int i = 0; i < n; i++) tick(rgb, 1'b1, 1'b0);
   endtask

   task automatic async_reset();
      #2 rst = 1'b0;
      model_reset();
      #1 check_all();
      #1 rst = 1'b1;
   endtask

   task automatic clear_all();
      tick({r, y, g}, 1'b1, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int cur, rem, u;
      logic [2:0] pat;
      logic [2:0] lamps [4];
      lamps[0] = 3'b000; lamps[1] = LR; lamps[2] = LG; lamps[3] = LY;
      model_reset();
      repeat (2) @(negedge clk);
      check_all();
      rst = 1'b1;

      // legal cycle
      hold(LR, 3); hold(LG, 3); hold(LY, 2); hold(LR, 3); hold(LR, 2);
      chk("tp_cycles", 32'(cycles), 32'd1);
      chk("tp_err_any", 32'(err_any), 32'd0);

      // yellow overstay then clear
      hold(LG, 3); hold(LY, 6); hold(LY, 1);
      chk("tp_ydwell", 32'(err_dwell), 32'd1);
      clear_all();
      chk("tp_yclr", 32'(err_dwell), 32'd0);

      // short green
      hold(LR, 3); hold(LG, 1); hold(LY, 2); hold(LR, 3); clear_all();

      // R->Y direct, then Y->R must not count
      hold(LR, 3); hold(LY, 3); hold(LR, 3); clear_all();

      // two lamps mid-red
      hold(LR, 3); hold(3'b101, 1); hold(LR, 4); clear_all();

      // freeze mid-green
      hold(LR, 3); hold(LG, 3);
      for (int i = 0; i < 5; i++) tick(LG, 1'b0, 1'b0);
      hold(LG, 3);

      // async reset mid-phase
      hold(LR, 2); async_reset(); hold(LR, 3);

      // clear coincident with order error
      hold(LY, 1); tick(LY, 1'b1, 1'b1);
      chk("tp_clr_vs_order", 32'(err_order), 32'd1);
      clear_all();

      // dwell saturation
      hold(LR, 300);
      chk("tp_sat", 32'(dwell), 32'(DMAX));

      // random mostly-legal traffic with faults, freezes, clears, resets
      cur = 1; rem = 0;
      for (int i = 0; i < 2500; i++) begin
         if (rem == 0) begin
            u = int'($urandom_range(0, 99));
            if (u < 16) cur = int'($urandom_range(1, 3));
            else cur = cur % 3 + 1;
            rem = int'($urandom_range(1, 6));
         end
         pat = lamps[cur];
         if ($urandom_range(0, 99) < 5) pat = 3'($urandom);
         tick(pat, ($urandom_range(0, 99) >= 6), ($urandom_range(0, 99) < 4));
         rem--;
         if ($urandom_range(0, 999) < 5) async_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule

// File: doc/stoplight_monitor.md
Name: stoplight_monitor

Overview:
- Passive observer on the far side of the stoplight controller's r/y/g outputs.
- Decodes the lamp pattern into a phase, measures dwell time per phase and counts completed light cycles.
- Flags illegal patterns, illegal phase order and dwell violations with sticky error flags.
- Sits beside the stoplight controller in the SSM integration bench and in synthesis as a hardware safety checker.

Parameters:
- CNT_W, 8, width of dwell counter (saturating)
- CYC_W, 16, width of completed-cycle counter (wrapping)
- G_MIN, 3, minimum legal green dwell in clk cycles
- Y_MIN, 2, minimum legal yellow dwell
- Y_MAX, 4, maximum legal yellow dwell
- R_MIN, 3, minimum legal red dwell

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- en  in  1  monitor enable; 0 freezes all state
- r  in  1  red lamp from controller
- y  in  1  yellow lamp from controller
- g  in  1  green lamp from controller
- clr_err  in  1  synchronous clear of sticky error flags
- phase  out  2  0=IDLE, 1=RED, 2=GRN, 3=YEL
- dwell  out  CNT_W  cycles spent in current phase
- cycles  out  CYC_W  completed legal R->G->Y->R cycles
- cycle_done  out  1  one-clk pulse on each cycles increment
- err_onehot  out  1  sticky: pattern not exactly one lamp lit
- err_order  out  1  sticky: illegal phase transition
- err_dwell  out  1  sticky: dwell below MIN or above Y_MAX
- err_any  out  1  OR of the three error flags (combinational from regs)

Behaviour:
- Reset (rst=0, async): phase=IDLE, dwell=0, cycles=0, cycle_done=0, all err_*=0, input sample reg=3'b000, armed=0.
- Inputs are registered once (s_rgb). FSM acts on s_rgb. A lamp change set up before edge N is reflected in phase/err after edge N+1 (2-edge latency).
- Decode: s_rgb one-hot gives RED/GRN/YEL. Any other pattern (000, or two or more bits set) is invalid.
- IDLE: on a valid pattern, enter that phase with dwell=1, no error checks. Invalid pattern: stay in IDLE, no error (startup blanking).
- Active phase, same valid pattern: dwell += 1, saturating at 2^CNT_W-1.
- Phase YEL: when dwell would exceed Y_MAX, set err_dwell once per phase visit. Stay in YEL.
- Active phase, legal change (RED->GRN, GRN->YEL, YEL->RED):
  - Check the exiting dwell against the exiting phase MIN; if below, set err_dwell.
  - Enter the new phase with dwell=1.
  - RED->GRN sets armed=1.
  - YEL->RED with armed=1: cycles += 1 (wraps), cycle_done=1 for one clk.
- Active phase, illegal change (any other valid->valid change): set err_order, enter the new phase with dwell=1, armed=0.
- Active phase, invalid pattern: set err_onehot, go to IDLE, dwell=0, armed=0.
- Errors are sticky. clr_err=1 clears them on the next edge. A new error event in the same cycle as clr_err wins: the flag ends at 1.
- en=0: s_rgb, phase, dwell, cycles, armed hold. No checks run and cycle_done=0; clr_err still acts.
- en 0->1: force phase=IDLE and armed=0 on the first enabled edge (resync); cycles is kept.
- rst asserted mid-phase returns everything to reset values immediately, independent of clk.

Decomposition:
- Shared package stoplight_pkg holds:
  - phase encoding constants PH_IDLE/PH_RED/PH_GRN/PH_YEL
  - the RGB one-hot constants used by stoplight and stoplight_monitor
- One sub-module, sat_counter (width param, inc/load1/clr, saturating), instantiated for dwell.
- FSM, cycle counter and error flags stay in the top module.

Test Plan:
- Legal sequence R×3, G×3, Y×2, R×3 after reset, en=1 -> phase tracks 1,2,3,1 with 2-edge lag; cycles=1; one cycle_done pulse at YEL->RED; err_any=0.
- Yellow held 6 clks -> err_dwell=1 on the 5th YEL dwell edge; phase stays 3. Then clr_err pulse -> err_dwell=0.
- G held only 1 clk before Y -> err_dwell=1 at the GRN->YEL transition; no err_order.
- R->Y direct -> err_order=1, phase=3, dwell=1. The following Y->R does not increment cycles (armed=0).
- r=1,g=1 for one clk mid-RED -> err_onehot=1, phase=0, dwell=0. Next valid R re-enters RED with no further errors.
- en=0 for 5 clks mid-GRN with dwell=2 -> dwell holds 2. On en=1, phase returns to IDLE then to GRN with dwell=1.
- rst pulsed low between clk edges -> all outputs 0 immediately.
- clr_err coincident with an order error -> err_order=1.
